// File: rtl/frequency_meter.sv
// Measures period and high time of a slow square wave in clk cycles.
// One measurement per start: wait for a rise, time high phase, then the full period.
module frequency_meter #(
  parameter int unsigned WIDTH = 26
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sig_in,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high_time
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    HIGH = 2'd2,
    LOW  = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  state_t           r_state;
  logic [WIDTH-1:0] r_cnt;
  logic             r_sync1;
  logic             r_sync2;
  logic             r_dly;
  logic [1:0]       r_fill;
  logic             r_seen_low;
  logic             r_busy;
  logic             r_done;
  logic             r_timeout;
  logic [WIDTH-1:0] r_period;
  logic [WIDTH-1:0] r_high_time;

  logic             w_rise;
  logic             w_fall;
  logic             w_at_max;
  logic [WIDTH-1:0] w_cnt_inc;

  // Synchronizer plus a guard so a level already high at reset release is not a rise
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_dly      <= 1'b0;
      r_fill     <= 2'b00;
      r_seen_low <= 1'b0;
    end else begin
      r_sync1    <= sig_in;
      r_sync2    <= r_sync1;
      r_dly      <= r_sync2;
      r_fill     <= {r_fill[0], 1'b1};
      r_seen_low <= r_seen_low | (r_fill[1] & ~r_sync2);
    end
  end

  assign w_rise    = r_sync2 & ~r_dly & r_seen_low;
  assign w_fall    = ~r_sync2 & r_dly;
  assign w_at_max  = (r_cnt == CNT_MAX);
  // Saturate so a fall captured at the last count cannot wrap into LOW
  assign w_cnt_inc = w_at_max ? r_cnt : r_cnt + CNT_ONE;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_timeout   <= 1'b0;
      r_period    <= '0;
      r_high_time <= '0;
    end else begin
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= ARM;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
          end
        end
        ARM: begin
          if (w_rise) begin
            r_cnt   <= CNT_ONE;
            r_state <= HIGH;
          end else if (w_at_max) begin
            r_timeout <= 1'b1;
            r_busy    <= 1'b0;
            r_state   <= IDLE;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        HIGH: begin
          // A rise here is handled exactly like a rise in LOW
          if (w_rise) begin
            r_period <= r_cnt;
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= IDLE;
          end else if (w_fall) begin
            r_high_time <= r_cnt;
            r_cnt       <= w_cnt_inc;
            r_state     <= LOW;
          end else if (w_at_max) begin
            r_timeout <= 1'b1;
            r_busy    <= 1'b0;
            r_state   <= IDLE;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        LOW: begin
          if (w_rise) begin
            r_period <= r_cnt;
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= IDLE;
          end else if (w_at_max) begin
            r_timeout <= 1'b1;
            r_busy    <= 1'b0;
            r_state   <= IDLE;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign timeout   = r_timeout;
  assign period    = r_period;
  assign high_time = r_high_time;

endmodule
